// File: rtl/wb_multi_sram_interface_if.sv
// Wishbone slave-side bus bundle for wb_multi_sram_interface.
// Signal names keep their original _i/_o suffixes, so existing connections map one-to-one.
interface wb_multi_sram_interface_if #(
  parameter int unsigned ADDR_WIDTH = 24
);
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [3:0]            wb_sel_i;
  logic [31:0]           wb_data_i;
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic                  wb_ack_o;
  logic                  wb_stall_o;
  logic                  wb_error_o;
  logic [31:0]           wb_data_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_data_i, wb_adr_i,
    input  wb_ack_o, wb_stall_o, wb_error_o, wb_data_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_data_i, wb_adr_i,
    output wb_ack_o, wb_stall_o, wb_error_o, wb_data_o
  );
endinterface

// File: rtl/wb_multi_sram_interface.sv
// Wishbone bridge onto several SRAM-like channels that share one address/data bus.
// The top address bits select the channel; a per-access busy timeout produces an error response.
module wb_multi_sram_interface #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned SEL_BITS   = 2,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  wb_multi_sram_interface_if.slave       wb,
  output logic [CHANNELS-1:0]            mem_enable,
  output logic                           mem_writeEnable,
  output logic [3:0]                     mem_byteSelect,
  output logic [ADDR_WIDTH-SEL_BITS-1:0] mem_address,
  output logic [31:0]                    mem_writeData,
  input  logic [CHANNELS*32-1:0]         mem_readData,
  input  logic [CHANNELS-1:0]            mem_busy
);

  localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned NSLOT = 2 ** SEL_BITS;
  localparam int unsigned MAW   = ADDR_WIDTH - SEL_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                ack_q;
  logic                err_q;
  logic                stall_q;
  logic [31:0]         data_q;

  logic [MAW-1:0]      lat_adr;
  logic [3:0]          lat_sel;
  logic [31:0]         lat_data;
  logic                lat_we;
  logic [SEL_BITS-1:0] lat_chan;

  logic [SEL_BITS-1:0] req_chan;
  logic                req_mapped;
  logic                req_valid;
  logic [NSLOT-1:0]    busy_pad;
  logic [NSLOT*32-1:0] rdata_pad;
  logic                cur_busy;
  logic [31:0]         cur_rdata;
  logic                timed_out;

  assign req_chan   = wb.wb_adr_i[ADDR_WIDTH-1 -: SEL_BITS];
  assign req_mapped = (32'(req_chan) < CHANNELS);
  assign req_valid  = wb.wb_cyc_i && wb.wb_stb_i;

  // Pad the per-channel inputs out to every decodable slot so the latched
  // channel index can select directly without out-of-range bit selects.
  assign busy_pad  = NSLOT'(mem_busy);
  assign rdata_pad = (NSLOT * 32)'(mem_readData);
  assign cur_busy  = busy_pad[lat_chan];
  assign cur_rdata = rdata_pad[{lat_chan, 5'd0} +: 32];
  assign timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_error_o = err_q;
  assign wb.wb_stall_o = stall_q;
  assign wb.wb_data_o  = data_q;

  // Request capture; these registers only matter once a request is accepted.
  always_ff @(posedge wb_clk_i) begin
    if (state == IDLE && req_valid) begin
      lat_adr  <= wb.wb_adr_i[MAW-1:0];
      lat_sel  <= wb.wb_sel_i;
      lat_data <= wb.wb_data_i;
      lat_we   <= wb.wb_we_i;
      lat_chan <= req_chan;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      data_q  <= '1;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          data_q <= '1;
          if (req_valid) begin
            stall_q <= 1'b1;
            if (req_mapped) begin
              state <= ACCESS;
              cnt   <= '0;
            end else begin
              state <= FINISH;
              err_q <= 1'b1;
            end
          end else begin
            stall_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (!wb.wb_cyc_i) begin
            state   <= IDLE;
            stall_q <= 1'b0;
          end else if (!cur_busy) begin
            state  <= FINISH;
            ack_q  <= 1'b1;
            data_q <= lat_we ? '1 : cur_rdata;
          end else if (timed_out) begin
            state  <= FINISH;
            err_q  <= 1'b1;
            data_q <= '1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          state   <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          stall_q <= 1'b0;
          data_q  <= '1;
        end
        default: begin
          state   <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          stall_q <= 1'b0;
          data_q  <= '1;
        end
      endcase
    end
  end

  // Shared memory bus is driven only while a channel is being accessed.
  always_comb begin
    mem_enable      = '0;
    mem_writeEnable = 1'b0;
    mem_byteSelect  = '0;
    mem_address     = '0;
    mem_writeData   = '0;
    if (state == ACCESS) begin
      mem_enable      = CHANNELS'(1) << lat_chan;
      mem_writeEnable = lat_we;
      mem_byteSelect  = lat_sel;
      mem_address     = lat_adr;
      mem_writeData   = lat_data;
    end
  end

endmodule
